// File: rtl/mult_pkg.sv
// +--------------------------------------------------------------------------+
// | mult_pkg : shared types for the sequential shift-add multiplier          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package mult_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_shift_add_multiplier_abs_neg_unit.sv
// +--------------------------------------------------------------------------+
// | abs_neg_unit : conditional two's-complement (abs on input, negate out)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module abs_neg_unit #(
  parameter int W = 8
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
// +--------------------------------------------------------------------------+
// | seq_shift_add_multiplier : radix-2 iterative WIDTH x WIDTH multiplier    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_t          r_state;
  logic [CNT_W-1:0]    r_count;
  logic [WIDTH-1:0]    r_mcand;
  logic [WIDTH-1:0]    r_acc_hi;
  logic [WIDTH-1:0]    r_acc_lo;
  logic                r_neg;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic [2*WIDTH-1:0]  r_p;

  logic                w_a_neg;
  logic                w_b_neg;
  logic [WIDTH-1:0]    w_a_abs;
  logic [WIDTH-1:0]    w_b_abs;
  logic [WIDTH-1:0]    w_addend;
  logic [WIDTH:0]      w_sum;
  logic [WIDTH-1:0]    w_acc_hi_nxt;
  logic [WIDTH-1:0]    w_acc_lo_nxt;
  logic [2*WIDTH-1:0]  w_prod_mag;
  logic [2*WIDTH-1:0]  w_prod;

  // Magnitudes are taken at accept; |min| fits in WIDTH bits unsigned.
  assign w_a_neg = is_signed & a[WIDTH-1];
  assign w_b_neg = is_signed & b[WIDTH-1];

  abs_neg_unit #(.W(WIDTH)) u_abs_a (
    .i_neg (w_a_neg),
    .i_val (a),
    .o_val (w_a_abs)
  );

  abs_neg_unit #(.W(WIDTH)) u_abs_b (
    .i_neg (w_b_neg),
    .i_val (b),
    .o_val (w_b_abs)
  );

  // Multiplier bits live in acc_lo and are consumed LSB first as the product shifts in.
  assign w_addend     = r_acc_lo[0] ? r_mcand : '0;
  assign w_sum        = {1'b0, r_acc_hi} + {1'b0, w_addend};
  assign w_acc_hi_nxt = w_sum[WIDTH:1];
  assign w_acc_lo_nxt = {w_sum[0], r_acc_lo[WIDTH-1:1]};
  assign w_prod_mag   = {w_acc_hi_nxt, w_acc_lo_nxt};

  abs_neg_unit #(.W(2*WIDTH)) u_neg_p (
    .i_neg (r_neg),
    .i_val (w_prod_mag),
    .o_val (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MUL_IDLE;
      r_count  <= '0;
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_neg    <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_p      <= '0;
    end else begin
      case (r_state)
        MUL_IDLE: begin
          r_done <= 1'b0;
          if (start && r_ready) begin
            r_mcand  <= w_a_abs;
            r_acc_lo <= w_b_abs;
            r_acc_hi <= '0;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_count  <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          r_acc_hi <= w_acc_hi_nxt;
          r_acc_lo <= w_acc_lo_nxt;
          // The final step's sum feeds p directly so the result lands on this edge.
          if (r_count == CNT_LAST) begin
            r_p     <= w_prod;
            r_done  <= 1'b1;
            r_state <= MUL_DONE;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        MUL_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= MUL_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= MUL_IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign p     = r_p;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
// +--------------------------------------------------------------------------+
// | tb_seq_shift_add_multiplier : directed bench for the shift-add multiplier|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_signed;
  logic [7:0]  a, b;
  logic        ready, busy, done;
  logic [15:0] p;

  logic        start4, is_signed4;
  logic [3:0]  a4, b4;
  logic        ready4, busy4, done4;
  logic [7:0]  p4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .p         (p)
  );

  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start4),
    .is_signed (is_signed4),
    .a         (a4),
    .b         (b4),
    .ready     (ready4),
    .busy      (busy4),
    .done      (done4),
    .p         (p4)
  );

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic sg,
                        output logic [15:0] op, output int lat);
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    a = ia; b = ib; is_signed = sg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    op = p;
  endtask

  task automatic run_op4(input logic [3:0] ia, input logic [3:0] ib, input logic sg,
                         output logic [7:0] op, output int lat);
    int w;
    w = 0;
    while (ready4 !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    a4 = ia; b4 = ib; is_signed4 = sg; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    while (done4 !== 1'b1 && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    op = p4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || p !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b p=%h, required ready=1 busy=0 done=0 p=0000",
               ready, busy, done, p);
    end
    n_checks++;
    if (ready4 !== 1'b1 || p4 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state_w4: ready=%b p=%h, required ready=1 p=00", ready4, p4);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    logic [15:0] r;
    int lat;
    run_op(8'd15, 8'd13, 1'b0, r, lat);
    n_checks++;
    if (r !== 16'd195) begin
      n_fail++; $display("FAIL unsigned_15x13: p=%0d, required 195", r);
    end
    n_checks++;
    if (lat !== 8) begin
      n_fail++; $display("FAIL unsigned_latency: done after %0d cycles, required 8", lat);
    end
    n_checks++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL done_state_flags: ready=%b busy=%b, required ready=0 busy=1", ready, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || p !== 16'd195) begin
      n_fail++;
      $display("FAIL done_pulse_width: done=%b ready=%b busy=%b p=%0d, required done=0 ready=1 busy=0 p=195",
               done, ready, busy, p);
    end
  endtask

  task automatic test_signed();
    logic [15:0] r;
    int lat;
    run_op(8'hFD, 8'h05, 1'b1, r, lat);
    n_checks++;
    if (r !== 16'hFFF1) begin
      n_fail++; $display("FAIL signed_m3x5: p=%h, required fff1", r);
    end
    run_op(8'h80, 8'h80, 1'b1, r, lat);
    n_checks++;
    if (r !== 16'h4000) begin
      n_fail++; $display("FAIL signed_min_x_min: p=%h, required 4000", r);
    end
    run_op(8'h05, 8'hFD, 1'b0, r, lat);
    n_checks++;
    if (r !== 16'h04F1) begin
      n_fail++; $display("FAIL unsigned_5xFD: p=%h, required 04f1", r);
    end
  endtask

  task automatic test_extremes();
    logic [15:0] r;
    int lat;
    run_op(8'hFF, 8'hFF, 1'b0, r, lat);
    n_checks++;
    if (r !== 16'hFE01) begin
      n_fail++; $display("FAIL unsigned_max: p=%h, required fe01", r);
    end
    run_op(8'h00, 8'hAB, 1'b0, r, lat);
    n_checks++;
    if (r !== 16'h0000 || lat !== 8) begin
      n_fail++; $display("FAIL zero_operand: p=%h latency=%0d, required p=0000 latency=8", r, lat);
    end
  endtask

  task automatic test_handshake();
    int cyc, ndone, first_cyc, second_cyc, w;
    logic [15:0] p1;
    bit hold_ok;
    w = 0;
    while (ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    a = 8'd15; b = 8'd13; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'd7; b = 8'd9;
    cyc = 0; ndone = 0; first_cyc = 0; second_cyc = 0; p1 = '0; hold_ok = 1'b1;
    while (ndone < 2 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          first_cyc = cyc; p1 = p;
        end else begin
          second_cyc = cyc; start = 1'b0;
        end
      end else if (ndone == 1 && p !== 16'd195) begin
        hold_ok = 1'b0;
      end
    end
    start = 1'b0;
    n_checks++;
    if (p1 !== 16'd195 || first_cyc !== 8) begin
      n_fail++; $display("FAIL handshake_first: p=%0d at cycle %0d, required 195 at cycle 8", p1, first_cyc);
    end
    n_checks++;
    if (!hold_ok) begin
      n_fail++; $display("FAIL handshake_hold: p changed between dones, required held at 195");
    end
    n_checks++;
    if (p !== 16'd63 || second_cyc !== 18) begin
      n_fail++; $display("FAIL handshake_second: p=%0d at cycle %0d, required 63 at cycle 18", p, second_cyc);
    end
  endtask

  task automatic test_reset_midop();
    logic [15:0] r;
    int lat, w, spurious;
    w = 0;
    while (ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    a = 8'd15; b = 8'd13; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (p !== 16'h0000 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop: p=%h ready=%b busy=%b done=%b, required p=0000 ready=1 busy=0 done=0",
               p, ready, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) spurious++;
    end
    n_checks++;
    if (spurious !== 0) begin
      n_fail++; $display("FAIL reset_no_done: %0d done pulses after abort, required 0", spurious);
    end
    run_op(8'd100, 8'd3, 1'b0, r, lat);
    n_checks++;
    if (r !== 16'd300 || lat !== 8) begin
      n_fail++; $display("FAIL post_reset_op: p=%0d latency=%0d, required p=300 latency=8", r, lat);
    end
  endtask

  task automatic test_random8();
    logic [15:0] r, exp_p;
    logic [7:0] ra, rb;
    logic sg;
    logic signed [15:0] sa, sb;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); sg = 1'($urandom);
      if (sg) begin
        sa = {{8{ra[7]}}, ra}; sb = {{8{rb[7]}}, rb};
        exp_p = 16'(sa * sb);
      end else begin
        exp_p = {8'h00, ra} * {8'h00, rb};
      end
      run_op(ra, rb, sg, r, lat);
      n_checks++;
      if (r !== exp_p || lat !== 8) begin
        n_fail++;
        $display("FAIL random_w8: a=%h b=%h signed=%b p=%h latency=%0d, required p=%h latency=8",
                 ra, rb, sg, r, lat, exp_p);
      end
    end
  endtask

  task automatic test_w4();
    logic [7:0] r, exp_p;
    logic [3:0] ra, rb;
    logic sg;
    logic signed [7:0] sa, sb;
    int lat;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        ra = 4'(i); rb = 4'(j);
        exp_p = {4'h0, ra} * {4'h0, rb};
        run_op4(ra, rb, 1'b0, r, lat);
        n_checks++;
        if (r !== exp_p || lat !== 4) begin
          n_fail++;
          $display("FAIL exhaustive_w4: a=%0d b=%0d p=%0d latency=%0d, required p=%0d latency=4",
                   ra, rb, r, lat, exp_p);
        end
      end
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); sg = 1'($urandom);
      if (sg) begin
        sa = {{4{ra[3]}}, ra}; sb = {{4{rb[3]}}, rb};
        exp_p = 8'(sa * sb);
      end else begin
        exp_p = {4'h0, ra} * {4'h0, rb};
      end
      run_op4(ra, rb, sg, r, lat);
      n_checks++;
      if (r !== exp_p) begin
        n_fail++;
        $display("FAIL random_w4: a=%h b=%h signed=%b p=%h, required %h", ra, rb, sg, r, exp_p);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    start4 = 1'b0; is_signed4 = 1'b0; a4 = '0; b4 = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_extremes();
    test_handshake();
    test_reset_midop();
    test_random8();
    test_w4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
